// File: rtl/skewed_input_feeder_if.sv
// Bus bundle for skewed_input_feeder: operand write port, start/stall control
// and the skewed lane outputs toward the systolic array edge.
interface skewed_input_feeder_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int NUM_VEC     = DEPTH / MATRIX_SIZE,
    parameter int VEC_W       = $clog2(NUM_VEC + 1)
);
    logic                                  wr_en;
    logic [ADDR_W-1:0]                     wr_addr;
    logic [DATA_SIZE-1:0]                  wr_data;
    logic                                  start;
    logic [VEC_W-1:0]                      num_vectors;
    logic                                  stall;
    logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] data_out;
    logic [MATRIX_SIZE-1:0]                valid_out;
    logic                                  busy;
    logic                                  done;

    modport master (
        output wr_en, wr_addr, wr_data, start, num_vectors, stall,
        input  data_out, valid_out, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, num_vectors, stall,
        output data_out, valid_out, busy, done
    );
endinterface

// File: rtl/skewed_input_feeder.sv
// Operand memory plus diagonal-skew streamer for a systolic array edge.
// Vector v (words v*MATRIX_SIZE .. v*MATRIX_SIZE+MATRIX_SIZE-1) is fetched in
// one cycle; lane i then travels through i+1 register stages so the array sees
// a wavefront delayed by one cycle per lane.
module skewed_input_feeder #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_SIZE   = 32,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int NUM_VEC     = DEPTH / MATRIX_SIZE,
    parameter int VEC_W       = $clog2(NUM_VEC + 1)
) (
    input logic                  clk,
    input logic                  reset,
    skewed_input_feeder_if.slave bus
);
    localparam int DRAIN_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    // Requests beyond the memory capacity saturate to the number of held vectors.
    function automatic logic [VEC_W-1:0] clamp_count(input logic [VEC_W-1:0] req);
        if (int'(req) > NUM_VEC) return VEC_W'(NUM_VEC);
        return req;
    endfunction

    logic [DATA_SIZE-1:0] dmem [DEPTH];

    logic [1:0]         state;
    logic [VEC_W-1:0]   vec_idx;
    logic [VEC_W-1:0]   vec_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               busy_r;
    logic               done_r;

    logic               fetch;
    logic               advance;
    logic [ADDR_W-1:0]  fetch_base;

    // A fetch happens on every non-stalled STREAM edge; the skew pipeline moves
    // on every edge except stalled ones (stall has no meaning in IDLE).
    assign fetch      = (state == S_STREAM) && !bus.stall;
    assign advance    = (state == S_IDLE) || !bus.stall;
    assign fetch_base = ADDR_W'(int'(vec_idx) * MATRIX_SIZE);

    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // Operand memory write port; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            dmem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer: IDLE -> STREAM (one fetch per vector) -> DRAIN (flush skew) -> IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            vec_idx   <= '0;
            vec_cnt   <= '0;
            drain_cnt <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && (bus.num_vectors != '0)) begin
                        vec_cnt <= clamp_count(bus.num_vectors);
                        vec_idx <= '0;
                        busy_r  <= 1'b1;
                        state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (!bus.stall) begin
                        vec_idx <= vec_idx + VEC_W'(1);
                        if (vec_idx == vec_cnt - VEC_W'(1)) begin
                            if (MATRIX_SIZE == 1) begin
                                // Single lane has no skew to flush.
                                state  <= S_IDLE;
                                busy_r <= 1'b0;
                                done_r <= 1'b1;
                            end else begin
                                drain_cnt <= '0;
                                state     <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!bus.stall) begin
                        // MATRIX_SIZE-1 flush edges, then the completing edge.
                        if (drain_cnt == DRAIN_W'(MATRIX_SIZE - 1)) begin
                            state  <= S_IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + DRAIN_W'(1);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
        logic [DATA_SIZE-1:0] dat_p [i+1];
        logic                 vld_p [i+1];
        logic [ADDR_W-1:0]    lane_addr;

        assign lane_addr = fetch_base + ADDR_W'(i);

        // Stage 0: new element on a fetch, empty slot otherwise.
        always_ff @(posedge clk) begin
            if (reset) begin
                dat_p[0] <= '0;
                vld_p[0] <= 1'b0;
            end else if (advance) begin
                dat_p[0] <= fetch ? dmem[lane_addr] : '0;
                vld_p[0] <= fetch;
            end
        end

        for (genvar s = 1; s <= i; s++) begin : g_stage
            // Skew stage s: plain delay, frozen during stall.
            always_ff @(posedge clk) begin
                if (reset) begin
                    dat_p[s] <= '0;
                    vld_p[s] <= 1'b0;
                end else if (advance) begin
                    dat_p[s] <= dat_p[s-1];
                    vld_p[s] <= vld_p[s-1];
                end
            end
        end

        assign bus.data_out[i]  = dat_p[i];
        assign bus.valid_out[i] = vld_p[i];
    end
endmodule

// File: tb/tb_skewed_input_feeder.sv
// Directed bench for skewed_input_feeder: a 2-lane and a 4-lane instance,
// expected lane streams derived from a bench-side copy of the operand memory.
module tb_skewed_input_feeder;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [31:0] mem2 [16];

    always #5 clk = ~clk;

    skewed_input_feeder_if #(.MATRIX_SIZE(2), .DATA_SIZE(32), .DEPTH(16)) b2 ();
    skewed_input_feeder_if #(.MATRIX_SIZE(4), .DATA_SIZE(32), .DEPTH(16)) b4 ();

    skewed_input_feeder #(.MATRIX_SIZE(2), .DATA_SIZE(32), .DEPTH(16)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (b2.slave)
    );

    skewed_input_feeder #(.MATRIX_SIZE(4), .DATA_SIZE(32), .DEPTH(16)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One streaming run on the 2-lane instance. Optional: stall window after
    // edge stall_at, colliding write at edge wr_at, ignored start at edge
    // restart_at, reset at the edge after abort_at.
    task automatic run2(input int nreq, input int stall_at, input int stall_n,
                        input int wr_at, input int restart_at, input int abort_at);
        int          cnt;
        int          total;
        int          adv;
        int          prev;
        logic [31:0] snap [16];
        logic [63:0] exp_d;
        logic [1:0]  exp_v;
        cnt   = (nreq > 8) ? 8 : nreq;
        total = cnt + 2;
        snap  = mem2;
        b2.start       = 1'b1;
        b2.num_vectors = 4'(nreq);
        tick();
        b2.start       = 1'b0;
        b2.num_vectors = 4'd3;
        check("t0_busy", 64'(b2.busy), 64'd1);
        check("t0_valid", 64'(b2.valid_out), 64'd0);
        adv = 0;
        for (int t = 1; t <= total + stall_n + 1; t++) begin
            b2.stall = (stall_at >= 0) && (t > stall_at) && (t <= stall_at + stall_n);
            b2.start = (t == restart_at);
            if (t == wr_at) begin
                b2.wr_en   = 1'b1;
                b2.wr_addr = 4'd2;
                b2.wr_data = 32'd99;
            end
            if (t == abort_at + 1) reset = 1'b1;
            tick();
            b2.wr_en = 1'b0;
            b2.start = 1'b0;
            if (t == wr_at) mem2[2] = 32'd99;
            if (t == abort_at + 1) begin
                reset = 1'b0;
                check("abort_data", b2.data_out, 64'd0);
                check("abort_valid", 64'(b2.valid_out), 64'd0);
                check("abort_busy", 64'(b2.busy), 64'd0);
                check("abort_done", 64'(b2.done), 64'd0);
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check("abort_no_done", 64'(b2.done), 64'd0);
                    check("abort_idle", 64'(b2.busy), 64'd0);
                end
                return;
            end
            prev = adv;
            if (!b2.stall) adv++;
            exp_d = '0;
            exp_v = '0;
            for (int i = 0; i < 2; i++) begin
                int v;
                v = adv - 1 - i;
                if (v >= 0 && v < cnt) begin
                    exp_v[i]          = 1'b1;
                    exp_d[i*32 +: 32] = snap[v*2 + i];
                end
            end
            check("lanes", b2.data_out, exp_d);
            check("valid", 64'(b2.valid_out), 64'(exp_v));
            check("busy", 64'(b2.busy), 64'(adv < total));
            check("done", 64'(b2.done), 64'((adv == total) && (prev == total - 1)));
        end
        b2.stall = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        b2.wr_en       = 1'b0;
        b2.wr_addr     = '0;
        b2.wr_data     = '0;
        b2.start       = 1'b0;
        b2.num_vectors = '0;
        b2.stall       = 1'b0;
        b4.wr_en       = 1'b0;
        b4.wr_addr     = '0;
        b4.wr_data     = '0;
        b4.start       = 1'b0;
        b4.num_vectors = '0;
        b4.stall       = 1'b0;
        repeat (2) tick();
        check("rst_data", b2.data_out, 64'd0);
        check("rst_valid", 64'(b2.valid_out), 64'd0);
        check("rst_busy", 64'(b2.busy), 64'd0);
        check("rst_done", 64'(b2.done), 64'd0);
        check("rst_valid4", 64'(b4.valid_out), 64'd0);
        reset = 1'b0;

        // Load dmem[k] = k+1 into both instances.
        for (int k = 0; k < 16; k++) begin
            mem2[k]    = 32'(k + 1);
            b2.wr_en   = 1'b1;
            b2.wr_addr = 4'(k);
            b2.wr_data = 32'(k + 1);
            b4.wr_en   = 1'b1;
            b4.wr_addr = 4'(k);
            b4.wr_data = 32'(k + 1);
            tick();
        end
        b2.wr_en = 1'b0;
        b4.wr_en = 1'b0;
        tick();

        // Plain run, then stalled run, then run with a start pulse while busy.
        run2(8, -1, 0, -1, -1, -1);
        run2(8, 3, 2, -1, -1, -1);
        run2(8, -1, 0, -1, 4, -1);

        // start with zero vectors is ignored.
        b2.start       = 1'b1;
        b2.num_vectors = 4'd0;
        tick();
        b2.start = 1'b0;
        check("zero_busy", 64'(b2.busy), 64'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("zero_done", 64'(b2.done), 64'd0);
            check("zero_valid", 64'(b2.valid_out), 64'd0);
        end

        // Oversized request clamps to 8 vectors.
        run2(15, -1, 0, -1, -1, -1);

        // Reset mid-run, then rerun from retained memory.
        run2(8, -1, 0, -1, -1, 5);
        run2(8, -1, 0, -1, -1, -1);

        // Write to word 2 on the edge that fetches vector 1, then rerun.
        run2(8, -1, 0, 2, -1, -1);
        run2(8, -1, 0, -1, -1, -1);

        // Four-lane instance: lane 0 shows 1,5,9,13 and lane 3 shows 4,8,12,16.
        b4.start       = 1'b1;
        b4.num_vectors = 3'd4;
        tick();
        b4.start = 1'b0;
        check("m4_t0_busy", 64'(b4.busy), 64'd1);
        for (int t = 1; t <= 9; t++) begin
            logic [31:0] e0;
            logic [31:0] e3;
            e0 = (t >= 1 && t <= 4) ? 32'(4 * (t - 1) + 1) : 32'd0;
            e3 = (t >= 4 && t <= 7) ? 32'(4 * (t - 3)) : 32'd0;
            tick();
            check("m4_lane0", 64'(b4.data_out[0]), 64'(e0));
            check("m4_lane3", 64'(b4.data_out[3]), 64'(e3));
            check("m4_valid3", 64'(b4.valid_out[3]), 64'(t >= 4 && t <= 7));
            check("m4_done", 64'(b4.done), 64'(t == 8));
            check("m4_busy", 64'(b4.busy), 64'(t < 8));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
